// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I immediate decode with a two-entry skid buffer.
// The opcode is decoded and the immediate extended combinationally on the input side.
// The result is captured when the instruction is accepted, so it appears one cycle later.
// o_ready comes only from registered state, so i_ready never reaches it combinationally.
module imm_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [2:0]            o_imm_type,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_illegal,
  output logic [CNT_WIDTH-1:0]  o_illegal_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  localparam logic [2:0] TYPE_I   = 3'b000;
  localparam logic [2:0] TYPE_S   = 3'b001;
  localparam logic [2:0] TYPE_B   = 3'b010;
  localparam logic [2:0] TYPE_J   = 3'b011;
  localparam logic [2:0] TYPE_U   = 3'b100;
  localparam logic [2:0] TYPE_CSR = 3'b101;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] dec_imm;
  logic [2:0]            dec_type;
  logic                  dec_illegal;

  logic [DATA_WIDTH-1:0] out_imm;
  logic [2:0]            out_type;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  out_illegal;

  logic [DATA_WIDTH-1:0] skid_imm;
  logic [2:0]            skid_type;
  logic [DATA_WIDTH-1:0] skid_pc;
  logic                  skid_illegal;

  logic [CNT_WIDTH-1:0]  illegal_cnt;

  logic accept;
  logic xfer;
  logic load_out_new;
  logic load_out_skid;
  logic load_skid;

  assign o_ready       = (state != ST_FULL);
  assign o_valid       = (state != ST_EMPTY);
  assign accept        = i_valid && o_ready;
  assign xfer          = o_valid && i_ready;
  assign o_imm_ext     = out_imm;
  assign o_imm_type    = out_type;
  assign o_pc          = out_pc;
  assign o_illegal     = out_illegal;
  assign o_illegal_cnt = illegal_cnt;

  // Classify the incoming opcode and build its sign/zero-extended immediate
  always_comb begin
    dec_type    = TYPE_I;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (i_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
        dec_type = TYPE_I;
        dec_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      7'b0100011: begin
        dec_type = TYPE_S;
        dec_imm  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      7'b1100011: begin
        dec_type = TYPE_B;
        dec_imm  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_type = TYPE_J;
        dec_imm  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type = TYPE_U;
        dec_imm  = {i_instr[31:12], 12'b0};
      end
      7'b1110011: begin
        if (i_instr[14]) begin
          dec_type = TYPE_CSR;
          dec_imm  = {27'b0, i_instr[19:15]};
        end else begin
          dec_type = TYPE_I;
          dec_imm  = {{20{i_instr[31]}}, i_instr[31:20]};
        end
      end
      7'b0110011: begin
        dec_type = TYPE_I;
        dec_imm  = '0;
      end
      default: begin
        dec_type    = TYPE_I;
        dec_imm     = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Work out the next buffer occupancy and which registers load this cycle
  always_comb begin
    state_next    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (i_flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_ONE;
            load_out_new = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            state_next   = ST_ONE;
            load_out_new = 1'b1;
          end else if (accept) begin
            state_next = ST_FULL;
            load_skid  = 1'b1;
          end else if (xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_next    = ST_ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // Advance the buffer state; reset takes priority over flush and handshakes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output register loads a fresh decode or the entry waiting in the skid register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_imm     <= '0;
      out_type    <= TYPE_I;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (load_out_new) begin
      out_imm     <= dec_imm;
      out_type    <= dec_type;
      out_pc      <= i_pc;
      out_illegal <= dec_illegal;
    end else if (load_out_skid) begin
      out_imm     <= skid_imm;
      out_type    <= skid_type;
      out_pc      <= skid_pc;
      out_illegal <= skid_illegal;
    end
  end

  // Skid register catches the second entry while the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_imm     <= '0;
      skid_type    <= TYPE_I;
      skid_pc      <= '0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_imm     <= dec_imm;
      skid_type    <= dec_type;
      skid_pc      <= i_pc;
      skid_illegal <= dec_illegal;
    end
  end

  // Count accepted illegal instructions, ignoring flushed inputs and saturating at the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_illegal && !i_flush && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage: directed scenarios followed by a randomized run.
// A queue-based reference model predicts every output.
// A second instance with a 4-bit counter shares the same stimulus to reach counter saturation quickly.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_imm_ext;
  logic [2:0]  o_imm_type;
  logic [31:0] o_pc;
  logic        o_illegal;
  logic [15:0] o_illegal_cnt;

  logic        s_ready;
  logic        s_valid;
  logic [31:0] s_imm_ext;
  logic [2:0]  s_imm_type;
  logic [31:0] s_pc;
  logic        s_illegal;
  logic [3:0]  s_illegal_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  typ;
    logic [31:0] pc;
    logic        ill;
  } entry_t;

  entry_t model_q[$];
  int     model_cnt16 = 0;
  int     model_cnt4  = 0;

  imm_decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_imm_ext    (o_imm_ext),
    .o_imm_type   (o_imm_type),
    .o_pc         (o_pc),
    .o_illegal    (o_illegal),
    .o_illegal_cnt(o_illegal_cnt)
  );

  imm_decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (s_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .o_valid      (s_valid),
    .i_ready      (i_ready),
    .o_imm_ext    (s_imm_ext),
    .o_imm_type   (s_imm_type),
    .o_pc         (s_pc),
    .o_illegal    (s_illegal),
    .o_illegal_cnt(s_illegal_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: immediates are built as weighted sums of instruction fields
  function automatic entry_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    entry_t e;
    logic [31:0] neg;
    e.pc  = pc;
    e.ill = 1'b0;
    e.typ = 3'd0;
    e.imm = 32'd0;
    neg   = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    if (ins[6:0] == 7'h13 || ins[6:0] == 7'h03 || ins[6:0] == 7'h67 || ins[6:0] == 7'h0F ||
        (ins[6:0] == 7'h73 && !ins[14])) begin
      e.typ = 3'd0;
      e.imm = (neg * 32'd2048) + 32'(ins[30:20]);
    end else if (ins[6:0] == 7'h23) begin
      e.typ = 3'd1;
      e.imm = (neg * 32'd2048) + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:7]);
    end else if (ins[6:0] == 7'h63) begin
      e.typ = 3'd2;
      e.imm = (neg * 32'd4096) + 32'(ins[7]) * 32'd2048 + 32'(ins[30:25]) * 32'd32 +
              32'(ins[11:8]) * 32'd2;
    end else if (ins[6:0] == 7'h6F) begin
      e.typ = 3'd3;
      e.imm = (neg * 32'd1048576) + 32'(ins[19:12]) * 32'd4096 + 32'(ins[20]) * 32'd2048 +
              32'(ins[30:21]) * 32'd2;
    end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
      e.typ = 3'd4;
      e.imm = 32'(ins[31:12]) * 32'd4096;
    end else if (ins[6:0] == 7'h73) begin
      e.typ = 3'd5;
      e.imm = 32'(ins[19:15]);
    end else if (ins[6:0] == 7'h33) begin
      e.typ = 3'd0;
      e.imm = 32'd0;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model's current prediction
  task automatic checkOutput(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(sz > 0));
    chk({tag, ".o_ready"}, 32'(o_ready), 32'(sz < 2));
    chk({tag, ".cnt16"}, 32'(o_illegal_cnt), 32'(model_cnt16));
    chk({tag, ".cnt4"}, 32'(s_illegal_cnt), 32'(model_cnt4));
    if (sz > 0) begin
      chk({tag, ".imm"}, o_imm_ext, model_q[0].imm);
      chk({tag, ".type"}, 32'(o_imm_type), 32'(model_q[0].typ));
      chk({tag, ".pc"}, o_pc, model_q[0].pc);
      chk({tag, ".illegal"}, 32'(o_illegal), 32'(model_q[0].ill));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] ins,
                               input logic [31:0] pc, input logic rdy, input logic fl,
                               input string tag);
    entry_t e;
    logic   acc;
    logic   xf;
    rst_n   = rst;
    i_valid = vld;
    i_instr = ins;
    i_pc    = pc;
    i_ready = rdy;
    i_flush = fl;
    @(posedge clk);
    if (!rst) begin
      model_q.delete();
      model_cnt16 = 0;
      model_cnt4  = 0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      acc = vld && (model_q.size() < 2);
      xf  = (model_q.size() > 0) && rdy;
      if (xf) void'(model_q.pop_front());
      if (acc) begin
        e = ref_decode(ins, pc);
        model_q.push_back(e);
        if (e.ill) begin
          if (model_cnt16 < 65535) model_cnt16++;
          if (model_cnt4 < 15) model_cnt4++;
        end
      end
    end
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h00};
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_instr = 32'd0;
    i_pc    = 32'd0;
    i_ready = 1'b0;
    i_flush = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "reset0");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h4, 1'b1, 1'b1, "reset1");
    chk("reset.imm", o_imm_ext, 32'd0);
    chk("reset.type", 32'(o_imm_type), 32'd0);
    chk("reset.pc", o_pc, 32'd0);
    chk("reset.illegal", 32'(o_illegal), 32'd0);
    chk("reset.ready", 32'(o_ready), 32'd1);

    // addi -1 appears one cycle after acceptance
    applyStimulus(1'b1, 1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0, "addi");
    chk("addi.imm", o_imm_ext, 32'hFFFF_FFFF);
    chk("addi.pc", o_pc, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "addi_drain");

    // lui then beq -4, in order
    applyStimulus(1'b1, 1'b1, 32'h12345037, 32'h200, 1'b1, 1'b0, "lui");
    chk("lui.imm", o_imm_ext, 32'h12345000);
    chk("lui.type", 32'(o_imm_type), 32'd4);
    applyStimulus(1'b1, 1'b1, 32'hFE000EE3, 32'h204, 1'b1, 1'b0, "beq");
    chk("beq.imm", o_imm_ext, 32'hFFFF_FFFC);
    chk("beq.type", 32'(o_imm_type), 32'd2);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "beq_drain");

    // Stall downstream with three instructions offered; only two fit
    applyStimulus(1'b1, 1'b1, 32'h00500113, 32'h300, 1'b0, 1'b0, "stall1");
    applyStimulus(1'b1, 1'b1, 32'h00112223, 32'h304, 1'b0, 1'b0, "stall2");
    chk("stall.ready_drop", 32'(o_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h008000EF, 32'h308, 1'b0, 1'b0, "stall3");
    applyStimulus(1'b1, 1'b1, 32'h008000EF, 32'h308, 1'b0, 1'b0, "stall_hold");
    applyStimulus(1'b1, 1'b1, 32'h008000EF, 32'h308, 1'b1, 1'b0, "release1");
    applyStimulus(1'b1, 1'b1, 32'h008000EF, 32'h308, 1'b1, 1'b0, "release2");
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "release3");
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "release4");

    // Flush while full, with an illegal input offered in the same cycle
    applyStimulus(1'b1, 1'b1, 32'h00A00093, 32'h400, 1'b0, 1'b0, "fill1");
    applyStimulus(1'b1, 1'b1, 32'h00B00093, 32'h404, 1'b0, 1'b0, "fill2");
    applyStimulus(1'b1, 1'b1, 32'h00000000, 32'h408, 1'b0, 1'b1, "flush");
    chk("flush.valid", 32'(o_valid), 32'd0);
    chk("flush.ready", 32'(o_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "flush_after");

    // Two illegal words are flagged and counted
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h500, 1'b1, 1'b0, "ill1");
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h504, 1'b1, 1'b0, "ill2");
    chk("ill2.flag", 32'(o_illegal), 32'd1);
    chk("ill2.cnt", 32'(o_illegal_cnt), 32'd2);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 32'h7F, 32'h600, 1'b1, 1'b0, "sat");
    chk("sat.cnt4", 32'(s_illegal_cnt), 32'hF);
    chk("sat.cnt16", 32'(o_illegal_cnt), 32'd18);

    // Reset while full
    applyStimulus(1'b1, 1'b1, 32'h00100093, 32'h700, 1'b0, 1'b0, "rfill1");
    applyStimulus(1'b1, 1'b1, 32'h00200093, 32'h704, 1'b0, 1'b0, "rfill2");
    applyStimulus(1'b0, 1'b1, 32'h00300093, 32'h708, 1'b1, 1'b0, "rst_full");
    chk("rst_full.valid", 32'(o_valid), 32'd0);
    chk("rst_full.ready", 32'(o_ready), 32'd1);
    chk("rst_full.cnt", 32'(o_illegal_cnt), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h00400093, 32'h70C, 1'b0, 1'b0, "post_rst");
    chk("post_rst.valid", 32'(o_valid), 32'd1);
    chk("post_rst.pc", o_pc, 32'h70C);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "post_rst_drain");

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rand_instr(),
                    $urandom(), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0),
                    "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, instruction/PC/immediate width; only 32 is supported.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  upstream instruction valid.
REQ-006 o_ready  output  1  stage can accept; a transfer occurs when i_valid && o_ready.
REQ-007 i_instr  input  32  RV32I instruction word.
REQ-008 i_pc  input  32  PC of i_instr.
REQ-009 i_flush  input  1  discard all held and incoming instructions.
REQ-010 o_valid  output  1  downstream result valid.
REQ-011 i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
REQ-012 o_imm_ext  output  32  extended immediate.
REQ-013 o_imm_type  output  3  type code: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR.
REQ-014 o_pc  output  32  PC carried with the result.
REQ-015 o_illegal  output  1  unsupported opcode flag for the presented result.
REQ-016 o_illegal_cnt  output  CNT_WIDTH  count of accepted illegal instructions, saturating.

Function
REQ-017 Opcode instr[6:0] maps to a type as follows: 0010011, 0000011, 1100111 and 0001111 map to I; 0100011 maps to S; 1100011 maps to B; 1101111 maps to J; 0110111 and 0010111 map to U.
REQ-018 Opcode 1110011 maps to CSR when instr[14]=1, and to I when instr[14]=0.
REQ-019 Opcode 0110011 (R-type) maps to type 000 with immediate 0 and is legal.
REQ-020 Any other opcode sets illegal=1, type 000 and immediate 0.
REQ-021 The immediate for each type is formed from instr bits as follows:
- I: sext(instr[31:20])
- S: sext({instr[31:25], instr[11:7]})
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
- U: {instr[31:12], 12'b0}
- CSR: zext(instr[19:15])
REQ-022 Decode and extension are combinational on the input side; results are captured at acceptance, giving 1-cycle latency from acceptance to o_valid.
REQ-023 Buffering is a 2-entry skid buffer (output register plus skid register) with states EMPTY, ONE and FULL.
REQ-024 o_ready = (state != FULL) and is driven from registered state only, with no combinational path from i_ready.
REQ-025 The state transitions are:
- EMPTY: on accept, go to ONE.
- ONE: on accept without output transfer, go to FULL; on output transfer without accept, go to EMPTY; otherwise hold.
- FULL: on output transfer, go to ONE and move the skid entry into the output register.
REQ-026 In ONE, a simultaneous accept and output transfer loads the new entry directly into the output register and the state stays ONE.
REQ-027 o_valid = (state != EMPTY); the output fields (o_imm_ext, o_imm_type, o_pc, o_illegal) hold stable while o_valid && !i_ready.
REQ-028 Strict FIFO order; no entry is dropped or duplicated.
REQ-029 i_flush has priority over all other events: the next state is EMPTY, any same-cycle accept is discarded, and o_illegal_cnt does not count that input.
REQ-030 o_illegal_cnt increments by 1 on each accept where illegal=1 and i_flush=0, and saturates at 2^CNT_WIDTH-1.
REQ-031 Flushing a held illegal entry does not decrement o_illegal_cnt.

Reset
REQ-032 While rst_n=0 at a rising edge, the next state is EMPTY and the outputs are: o_valid=0, o_ready=1, o_imm_ext=0, o_imm_type=000, o_pc=0, o_illegal=0, o_illegal_cnt=0.
REQ-033 Reset asserted mid-transfer discards all held entries; the first accept after release is the first output.
REQ-034 Reset has priority over i_flush and over any handshake.

Verification
REQ-035 Accept i_instr=0xFFF00093 (addi -1), i_pc=0x100 -> next cycle o_valid=1, o_imm_ext=0xFFFFFFFF, o_imm_type=000, o_pc=0x100.
REQ-036 Accept 0x12345037 (lui), then 0xFE000EE3 (beq -4) -> o_imm_ext 0x12345000 with type 100, then 0xFFFFFFFC with type 010, in order.
REQ-037 Hold i_ready=0 and present three valid instructions back-to-back -> o_ready drops after 2 accepts; then raise i_ready -> all accepted entries emerge in order with stable fields while stalled.
REQ-038 Hold the buffer FULL and assert i_flush with i_valid=1 -> the next cycle has o_valid=0, o_ready=1, and the flushed input never appears at the output.
REQ-039 Accept 0x00000000 twice -> o_illegal=1 on both results and o_illegal_cnt=2; preload the counter near 0xFFFF -> it saturates at 0xFFFF.
REQ-040 Assert rst_n=0 for one cycle while FULL -> o_valid=0, o_ready=1, o_illegal_cnt=0, and the first accept after release appears with 1-cycle latency.
